tbus_arbiter: RTL and testbench
===============================

Name: tbus_arbiter

Overview:
- Two-requester arbiter and sequencer for the single Trinity bus (tbus) port.
- Requester 0 is instruction fetch. Requester 1 is memblock (load/store).
- Arbitrates round-robin, latches the winning request, drives the tbus index handshake, waits for tbus_operation_done, and steers read data and completion back to the owner.
- Sits between the fetch/memblock tbus ports and the memory-side tbus.

Parameters:
- ADDR_W, 64, tbus index width (matches RESULT width)
- DATA_W, 64, write/read data width
- MASK_W, 64, byte-lane write mask width
- OPTYPE_W, 2, tbus operation type width
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req{0,1}_index_valid  in  1  request valid from requester n
- req{0,1}_index_ready  out  1  request accepted (1-cycle pulse)
- req{0,1}_index  in  ADDR_W  address
- req{0,1}_write_data  in  DATA_W  store data
- req{0,1}_write_mask  in  MASK_W  store byte mask
- req{0,1}_operation_type  in  OPTYPE_W  read/write type
- req{0,1}_read_data  out  DATA_W  returned data, valid with done
- req{0,1}_operation_done  out  1  completion pulse to owner
- tbus_index_valid  out  1  downstream request valid
- tbus_index_ready  in  1  downstream accept
- tbus_index  out  ADDR_W  latched address
- tbus_write_data  out  DATA_W  latched data
- tbus_write_mask  out  MASK_W  latched mask
- tbus_operation_type  out  OPTYPE_W  latched type
- tbus_read_data  in  DATA_W  downstream read data
- tbus_operation_done  in  1  downstream completion
- timeout_err  out  1  watchdog abort pulse (tied 0 without the optional feature)

Behaviour:
- State machine, 2-bit state: IDLE, ISSUE, WAIT.
- Reset: state=IDLE, last_grant=1 (port 0 wins the first tie), owner=0, all latched payload=0, every output=0. Reset applies at any time, including mid-operation. An in-flight downstream op is abandoned; the downstream side is reset concurrently.
- IDLE:
  - If exactly one reqN_index_valid is high, grant N.
  - If both are high, grant the port other than last_grant.
  - On grant, reqN_index_ready=1 combinationally in the same cycle; payload is latched into registers; owner=N; last_grant=N; next state=ISSUE.
  - reqN_index_ready is never high outside IDLE and never high for both ports at once.
- ISSUE:
  - tbus_index_valid=1 and tbus_* driven from registers; the payload stays stable until tbus_index_ready.
  - On tbus_index_ready, go to WAIT.
  - If tbus_index_ready and tbus_operation_done are high in the same cycle, complete immediately (see WAIT) and go to IDLE.
- WAIT:
  - tbus_index_valid=0.
  - On tbus_operation_done, pass req[owner]_operation_done=1 and req[owner]_read_data=tbus_read_data combinationally in the same cycle; next state=IDLE.
  - The non-owner port's done and read_data stay 0.
- tbus_operation_done is ignored in IDLE, and in ISSUE without ready (stray pulses dropped).
- reqN_read_data is 0 whenever reqN_operation_done is 0.
- Latency:
  - Request accepted at cycle N, tbus_index_valid at N+1.
  - Done forwarded in the same cycle it arrives.
  - Minimum of one IDLE cycle between transactions; back-to-back grant is possible in that IDLE cycle.
- Requesters must hold valid/payload until ready, and must not drop valid once asserted. The arbiter does not check this.
- No flush input: a flushed requester still consumes its completion pulse.

Optional Feature:
- Macro: TBUS_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 without completion, the arbiter pulses req[owner]_operation_done=1 with read_data=0 and timeout_err=1 for one cycle, then goes to IDLE.
  - A late tbus_operation_done for the aborted op is ignored in IDLE.
- When undefined: no counter exists, timeout_err is constant 0, and WAIT waits indefinitely.

Test Plan:
- Single read, port 1: req1 index=0x8000_0010, type=read → ready1 pulse same cycle; tbus_index_valid next cycle with index 0x8000_0010; ready after 2 cycles; done with read_data=0xDEAD_BEEF_0000_1234 → done1=1 with that data same cycle, done0=0.
- Tie: req0 and req1 both valid from reset → port 0 granted first, port 1 granted in the IDLE cycle after port 0's done. Repeat the tie → port 0 again (strict alternation).
- Backpressure: hold tbus_index_ready=0 for 5 cycles → tbus_index, write_data=0x1122334455667788, mask=0xFF stable all 5 cycles; valid stays 1.
- Same-cycle ready+done in ISSUE → owner done pulse that cycle, state IDLE next cycle, tbus_index_valid low.
- Reset in WAIT with tbus_operation_done arriving the cycle after reset deasserts → no reqN_operation_done, all outputs 0, next request granted normally.
- With TBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: never assert done → timeout_err and done0 pulse at the 8th cycle after ISSUE entry, read_data0=0; a later stray done is ignored.

Source files
------------

// File: rtl/tbus_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single tbus port.
// Optional watchdog abort is enabled with the TBUS_ARB_TIMEOUT_EN macro.
//
// state | meaning
// IDLE  | no operation in flight, arbitrate and latch the winning request
// ISSUE | latched request presented on tbus, waiting for tbus_index_ready
// WAIT  | request accepted downstream, waiting for tbus_operation_done
module tbus_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MASK_W         = 64,
    parameter int OPTYPE_W       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req0_index_valid,
    output logic                req0_index_ready,
    input  logic [ADDR_W-1:0]   req0_index,
    input  logic [DATA_W-1:0]   req0_write_data,
    input  logic [MASK_W-1:0]   req0_write_mask,
    input  logic [OPTYPE_W-1:0] req0_operation_type,
    output logic [DATA_W-1:0]   req0_read_data,
    output logic                req0_operation_done,

    input  logic                req1_index_valid,
    output logic                req1_index_ready,
    input  logic [ADDR_W-1:0]   req1_index,
    input  logic [DATA_W-1:0]   req1_write_data,
    input  logic [MASK_W-1:0]   req1_write_mask,
    input  logic [OPTYPE_W-1:0] req1_operation_type,
    output logic [DATA_W-1:0]   req1_read_data,
    output logic                req1_operation_done,

    output logic                tbus_index_valid,
    input  logic                tbus_index_ready,
    output logic [ADDR_W-1:0]   tbus_index,
    output logic [DATA_W-1:0]   tbus_write_data,
    output logic [MASK_W-1:0]   tbus_write_mask,
    output logic [OPTYPE_W-1:0] tbus_operation_type,
    input  logic [DATA_W-1:0]   tbus_read_data,
    input  logic                tbus_operation_done,

    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("tbus_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    state_t              state;
    logic                last_grant;
    logic                owner;
    logic [ADDR_W-1:0]   index_q;
    logic [DATA_W-1:0]   write_data_q;
    logic [MASK_W-1:0]   write_mask_q;
    logic [OPTYPE_W-1:0] operation_type_q;

    logic grant_any;
    logic grant_sel;
    logic complete;
    logic abort;
    logic finish;

    // Reset gates the combinational handshakes so every output is 0 while reset is held.
    assign grant_any = !reset && (state == IDLE) && (req0_index_valid || req1_index_valid);
    assign grant_sel = (req0_index_valid && req1_index_valid) ? ~last_grant : req1_index_valid;
    assign complete  = !reset && tbus_operation_done &&
                       (((state == ISSUE) && tbus_index_ready) || (state == WAIT));
    assign finish    = complete || abort;

`ifdef TBUS_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // A real completion in the terminal cycle wins over the abort.
    assign abort = !reset && (state != IDLE) && !complete &&
                   (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    assign timeout_err = abort;

    assign req0_index_ready    = grant_any && !grant_sel;
    assign req1_index_ready    = grant_any && grant_sel;
    assign req0_operation_done = finish && !owner;
    assign req1_operation_done = finish && owner;
    assign req0_read_data      = (complete && !owner) ? tbus_read_data : '0;
    assign req1_read_data      = (complete && owner)  ? tbus_read_data : '0;

    assign tbus_index_valid    = !reset && (state == ISSUE);
    assign tbus_index          = index_q;
    assign tbus_write_data     = write_data_q;
    assign tbus_write_mask     = write_mask_q;
    assign tbus_operation_type = operation_type_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            index_q          <= '0;
            write_data_q     <= '0;
            write_mask_q     <= '0;
            operation_type_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner            <= grant_sel;
                        last_grant       <= grant_sel;
                        index_q          <= grant_sel ? req1_index          : req0_index;
                        write_data_q     <= grant_sel ? req1_write_data     : req0_write_data;
                        write_mask_q     <= grant_sel ? req1_write_mask     : req0_write_mask;
                        operation_type_q <= grant_sel ? req1_operation_type : req0_operation_type;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (finish) begin
                        state <= IDLE;
                    end else if (tbus_index_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (finish) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed self-checking bench for tbus_arbiter: arbitration, handshake, backpressure,
// reset recovery, and the watchdog abort when built with TBUS_ARB_TIMEOUT_EN.
module tb_tbus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req0_index_valid = 1'b0, req1_index_valid = 1'b0;
    logic        req0_index_ready, req1_index_ready;
    logic [63:0] req0_index = '0, req1_index = '0;
    logic [63:0] req0_write_data = '0, req1_write_data = '0;
    logic [63:0] req0_write_mask = '0, req1_write_mask = '0;
    logic [1:0]  req0_operation_type = '0, req1_operation_type = '0;
    logic [63:0] req0_read_data, req1_read_data;
    logic        req0_operation_done, req1_operation_done;

    logic        tbus_index_valid;
    logic        tbus_index_ready = 1'b0;
    logic [63:0] tbus_index, tbus_write_data, tbus_write_mask;
    logic [1:0]  tbus_operation_type;
    logic [63:0] tbus_read_data = '0;
    logic        tbus_operation_done = 1'b0;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tbus_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MASK_W(64), .OPTYPE_W(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset),
        .req0_index_valid(req0_index_valid), .req0_index_ready(req0_index_ready),
        .req0_index(req0_index), .req0_write_data(req0_write_data),
        .req0_write_mask(req0_write_mask), .req0_operation_type(req0_operation_type),
        .req0_read_data(req0_read_data), .req0_operation_done(req0_operation_done),
        .req1_index_valid(req1_index_valid), .req1_index_ready(req1_index_ready),
        .req1_index(req1_index), .req1_write_data(req1_write_data),
        .req1_write_mask(req1_write_mask), .req1_operation_type(req1_operation_type),
        .req1_read_data(req1_read_data), .req1_operation_done(req1_operation_done),
        .tbus_index_valid(tbus_index_valid), .tbus_index_ready(tbus_index_ready),
        .tbus_index(tbus_index), .tbus_write_data(tbus_write_data),
        .tbus_write_mask(tbus_write_mask), .tbus_operation_type(tbus_operation_type),
        .tbus_read_data(tbus_read_data), .tbus_operation_done(tbus_operation_done),
        .timeout_err(timeout_err)
    );

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        req0_index_valid    = 1'b1;
        tbus_operation_done = 1'b1;
        tick();
        #1;
        checks++; if (req0_index_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_index_ready); end
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL reset_tbus_valid: got %b want 0", tbus_index_valid); end
        checks++; if (req0_operation_done !== 1'b0) begin errors++; $display("FAIL reset_done0: got %b want 0", req0_operation_done); end
        checks++; if (tbus_index !== 64'h0) begin errors++; $display("FAIL reset_index: got %h want 0", tbus_index); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        tick();
        reset               = 1'b0;
        req0_index_valid    = 1'b0;
        #1;
        checks++; if (tbus_operation_done === 1'b1 && req0_operation_done !== 1'b0) begin errors++; $display("FAIL reset_idle_stray_done: got %b want 0", req0_operation_done); end
        tbus_operation_done = 1'b0;
    endtask

    task automatic test_single_read();
        tick();
        req1_index_valid    = 1'b1;
        req1_index          = 64'h8000_0010;
        req1_operation_type = 2'd0;
        #1;
        checks++; if (req1_index_ready !== 1'b1) begin errors++; $display("FAIL single_ready1: got %b want 1", req1_index_ready); end
        checks++; if (req0_index_ready !== 1'b0) begin errors++; $display("FAIL single_ready0: got %b want 0", req0_index_ready); end
        tick();
        req1_index_valid = 1'b0;
        #1;
        checks++; if (tbus_index_valid !== 1'b1) begin errors++; $display("FAIL single_tbus_valid: got %b want 1", tbus_index_valid); end
        checks++; if (tbus_index !== 64'h8000_0010) begin errors++; $display("FAIL single_tbus_index: got %h want 8000_0010", tbus_index); end
        checks++; if (req1_index_ready !== 1'b0) begin errors++; $display("FAIL single_ready1_issue: got %b want 0", req1_index_ready); end
        tick();
        tbus_index_ready = 1'b1;
        #1;
        checks++; if (tbus_index_valid !== 1'b1) begin errors++; $display("FAIL single_tbus_valid_hold: got %b want 1", tbus_index_valid); end
        tick();
        tbus_index_ready = 1'b0;
        #1;
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL single_wait_valid: got %b want 0", tbus_index_valid); end
        tick();
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'hDEAD_BEEF_0000_1234;
        #1;
        checks++; if (req1_operation_done !== 1'b1) begin errors++; $display("FAIL single_done1: got %b want 1", req1_operation_done); end
        checks++; if (req1_read_data !== 64'hDEAD_BEEF_0000_1234) begin errors++; $display("FAIL single_rdata1: got %h want DEAD_BEEF_0000_1234", req1_read_data); end
        checks++; if (req0_operation_done !== 1'b0) begin errors++; $display("FAIL single_done0: got %b want 0", req0_operation_done); end
        checks++; if (req0_read_data !== 64'h0) begin errors++; $display("FAIL single_rdata0: got %h want 0", req0_read_data); end
        tick();
        tbus_operation_done = 1'b0;
        #1;
        checks++; if (req1_operation_done !== 1'b0) begin errors++; $display("FAIL single_done1_after: got %b want 0", req1_operation_done); end
        checks++; if (req1_read_data !== 64'h0) begin errors++; $display("FAIL single_rdata1_after: got %h want 0", req1_read_data); end
        tbus_read_data = '0;
    endtask

    task automatic test_tie();
        tick();
        reset = 1'b1;
        tick();
        reset            = 1'b0;
        req0_index_valid = 1'b1;
        req1_index_valid = 1'b1;
        req0_index       = 64'hA0;
        req1_index       = 64'hB0;
        #1;
        checks++; if (req0_index_ready !== 1'b1 || req1_index_ready !== 1'b0) begin errors++; $display("FAIL tie_first: got r0=%b r1=%b want r0=1 r1=0", req0_index_ready, req1_index_ready); end
        tick();
        req0_index_valid = 1'b0;
        tbus_index_ready = 1'b1;
        #1;
        checks++; if (tbus_index !== 64'hA0) begin errors++; $display("FAIL tie_index0: got %h want a0", tbus_index); end
        checks++; if (req1_index_ready !== 1'b0) begin errors++; $display("FAIL tie_ready1_busy: got %b want 0", req1_index_ready); end
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'h55;
        #1;
        checks++; if (req0_operation_done !== 1'b1 || req1_operation_done !== 1'b0) begin errors++; $display("FAIL tie_done0: got d0=%b d1=%b want d0=1 d1=0", req0_operation_done, req1_operation_done); end
        tick();
        tbus_operation_done = 1'b0;
        #1;
        checks++; if (req1_index_ready !== 1'b1) begin errors++; $display("FAIL tie_second_grant: got %b want 1", req1_index_ready); end
        tick();
        req1_index_valid    = 1'b0;
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (tbus_index !== 64'hB0) begin errors++; $display("FAIL tie_index1: got %h want b0", tbus_index); end
        checks++; if (req1_operation_done !== 1'b1) begin errors++; $display("FAIL tie_done1: got %b want 1", req1_operation_done); end
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        req0_index_valid    = 1'b1;
        req1_index_valid    = 1'b1;
        #1;
        checks++; if (req0_index_ready !== 1'b1 || req1_index_ready !== 1'b0) begin errors++; $display("FAIL tie_repeat: got r0=%b r1=%b want r0=1 r1=0", req0_index_ready, req1_index_ready); end
        tick();
        req0_index_valid    = 1'b0;
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        #1;
        checks++; if (req1_index_ready !== 1'b1) begin errors++; $display("FAIL tie_repeat_second: got %b want 1", req1_index_ready); end
        tick();
        req1_index_valid    = 1'b0;
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
    endtask

    task automatic test_backpressure();
        req0_index_valid    = 1'b1;
        req0_index          = 64'h100;
        req0_write_data     = 64'h1122_3344_5566_7788;
        req0_write_mask     = 64'hFF;
        req0_operation_type = 2'd1;
        #1;
        checks++; if (req0_index_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b want 1", req0_index_ready); end
        tick();
        req0_index_valid    = 1'b0;
        req0_index          = 64'hBAD;
        req0_write_data     = 64'hBAD;
        req0_write_mask     = 64'h0;
        for (int i = 0; i < 5; i++) begin
            tbus_operation_done = (i == 2);
            #1;
            checks++; if (tbus_index_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, tbus_index_valid); end
            checks++; if (tbus_index !== 64'h100 || tbus_write_data !== 64'h1122_3344_5566_7788 || tbus_write_mask !== 64'hFF || tbus_operation_type !== 2'd1)
                begin errors++; $display("FAIL bp_payload[%0d]: got %h/%h/%h/%0d want 100/1122334455667788/ff/1", i, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type); end
            checks++; if (req0_operation_done !== 1'b0) begin errors++; $display("FAIL bp_stray_done[%0d]: got %b want 0", i, req0_operation_done); end
            tick();
        end
        tbus_operation_done = 1'b0;
        tbus_index_ready    = 1'b1;
        #1;
        checks++; if (tbus_index_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_accept: got %b want 1", tbus_index_valid); end
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (req0_operation_done !== 1'b1) begin errors++; $display("FAIL bp_done0: got %b want 1", req0_operation_done); end
        tick();
        tbus_operation_done = 1'b0;
    endtask

    task automatic test_ready_done_same();
        req1_index_valid = 1'b1;
        req1_index       = 64'h200;
        #1;
        checks++; if (req1_index_ready !== 1'b1) begin errors++; $display("FAIL same_ready1: got %b want 1", req1_index_ready); end
        tick();
        req1_index_valid    = 1'b0;
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'hCAFE;
        #1;
        checks++; if (req1_operation_done !== 1'b1 || req1_read_data !== 64'hCAFE) begin errors++; $display("FAIL same_done1: got %b/%h want 1/cafe", req1_operation_done, req1_read_data); end
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        req0_index_valid    = 1'b1;
        #1;
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL same_idle_valid: got %b want 0", tbus_index_valid); end
        checks++; if (req1_operation_done !== 1'b0) begin errors++; $display("FAIL same_done1_after: got %b want 0", req1_operation_done); end
        checks++; if (req0_index_ready !== 1'b1) begin errors++; $display("FAIL same_idle_grant: got %b want 1", req0_index_ready); end
        tick();
        req0_index_valid    = 1'b0;
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
    endtask

    task automatic test_reset_in_wait();
        req0_index_valid = 1'b1;
        req0_index       = 64'h300;
        tick();
        req0_index_valid = 1'b0;
        tbus_index_ready = 1'b1;
        tick();
        tbus_index_ready = 1'b0;
        #1;
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_state: got %b want 0", tbus_index_valid); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (req0_operation_done !== 1'b0 || tbus_index_valid !== 1'b0) begin errors++; $display("FAIL rst_during: got d0=%b v=%b want 0/0", req0_operation_done, tbus_index_valid); end
        tick();
        reset               = 1'b0;
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'h77;
        #1;
        checks++; if (req0_operation_done !== 1'b0 || req1_operation_done !== 1'b0) begin errors++; $display("FAIL rst_late_done: got d0=%b d1=%b want 0/0", req0_operation_done, req1_operation_done); end
        checks++; if (req0_read_data !== 64'h0 || tbus_index !== 64'h0 || tbus_index_valid !== 1'b0) begin errors++; $display("FAIL rst_outputs: got rd0=%h idx=%h v=%b want 0/0/0", req0_read_data, tbus_index, tbus_index_valid); end
        tick();
        tbus_operation_done = 1'b0;
        req1_index_valid    = 1'b1;
        req1_index          = 64'h400;
        #1;
        checks++; if (req1_index_ready !== 1'b1) begin errors++; $display("FAIL rst_regrant: got %b want 1", req1_index_ready); end
        tick();
        req1_index_valid    = 1'b0;
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (req1_operation_done !== 1'b1 || req1_read_data !== 64'h77 || tbus_index !== 64'h400) begin errors++; $display("FAIL rst_regrant_done: got %b/%h/%h want 1/77/400", req1_operation_done, req1_read_data, tbus_index); end
        tick();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
    endtask

`ifdef TBUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req0_index_valid = 1'b1;
        req0_index       = 64'h500;
        tick();
        req0_index_valid = 1'b0;
        tbus_read_data   = 64'hFFFF;
        for (int k = 1; k < 8; k++) begin
            #1;
            checks++; if (timeout_err !== 1'b0 || req0_operation_done !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got te=%b d0=%b want 0/0", k, timeout_err, req0_operation_done); end
            tick();
        end
        #1;
        checks++; if (timeout_err !== 1'b1 || req0_operation_done !== 1'b1) begin errors++; $display("FAIL to_fire: got te=%b d0=%b want 1/1", timeout_err, req0_operation_done); end
        checks++; if (req0_read_data !== 64'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", req0_read_data); end
        tick();
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (timeout_err !== 1'b0 || req0_operation_done !== 1'b0 || tbus_index_valid !== 1'b0) begin errors++; $display("FAIL to_stray: got te=%b d0=%b v=%b want 0/0/0", timeout_err, req0_operation_done, tbus_index_valid); end
        tick();
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_backpressure();
        test_ready_done_same();
        test_reset_in_wait();
`ifdef TBUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
